// File: rtl/seg_scan_decoder.sv
// Snoops an active-low multiplexed 4-digit 7-segment bus and recovers the hex value on each digit.
// Optional build macro SEGDEC_STICKY_ERR_EN: sticky digit_err bits with an err_clr input.
module seg_scan_decoder #(
    parameter int          STABLE_CYCLES = 4,
    parameter logic [3:0]  DIGIT_MASK    = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_L,
    input  logic [3:0]  anode_L,
`ifdef SEGDEC_STICKY_ERR_EN
    input  logic        err_clr,
`endif
    output logic [15:0] digit_val,
    output logic [3:0]  digit_vld,
    output logic [3:0]  digit_err,
    output logic        frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [6:0]    seg_s1, seg_s2, seg_p;
    logic [3:0]    an_s1, an_s2, an_p;
    logic [CW-1:0] cnt;
    logic [3:0]    seen;

    logic [6:0]    seg_on;
    logic [3:0]    an_on;
    logic          one_hot, same, capture, full, dec_hit, blank;
    logic [1:0]    idx;
    logic [3:0]    dec_hex;

    // Returns {hit, hex}; hit is 0 for any pattern outside the 16 glyphs.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        seg_on  = ~seg_s2;
        an_on   = ~an_s2;
        one_hot = $onehot(an_on);
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_on[i]) idx = 2'(i);
        end
        same    = (seg_s2 == seg_p) && (an_s2 == an_p);
        capture = one_hot && same && (cnt == CW'(STABLE_CYCLES - 1));
        {dec_hit, dec_hex} = decode(seg_on);
        blank   = (seg_on == 7'h00);
        full    = (DIGIT_MASK != 4'b0000) && ((seen & DIGIT_MASK) == DIGIT_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
            seg_p  <= '0;
            an_p   <= '0;
            cnt    <= '0;
        end else begin
            seg_s1 <= seg_L;
            seg_s2 <= seg_s1;
            an_s1  <= anode_L;
            an_s2  <= an_s1;
            seg_p  <= seg_s2;
            an_p   <= an_s2;
            // Counter saturates so a held pattern captures exactly once.
            if (!one_hot || !same)
                cnt <= '0;
            else if (cnt != CW'(STABLE_CYCLES))
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val  <= '0;
            digit_vld  <= '0;
            digit_err  <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= full;
            if (full)
                seen <= capture ? (4'b0001 << idx) : 4'b0000;
            else if (capture)
                seen <= seen | (4'b0001 << idx);

            if (capture) begin
                if (dec_hit) begin
                    digit_val[{idx, 2'b00} +: 4] <= dec_hex;
                    digit_vld[idx]               <= 1'b1;
`ifndef SEGDEC_STICKY_ERR_EN
                    digit_err[idx]               <= 1'b0;
`endif
                end else begin
                    digit_vld[idx] <= 1'b0;
`ifdef SEGDEC_STICKY_ERR_EN
                    digit_err[idx] <= digit_err[idx] | ~blank;
`else
                    digit_err[idx] <= ~blank;
`endif
                end
            end
`ifdef SEGDEC_STICKY_ERR_EN
            // Placed last so a clear overrides a same-cycle set.
            if (err_clr)
                digit_err <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: latency, scan/frame, glitch, bad pattern, idle, reset.
// Handles both default and SEGDEC_STICKY_ERR_EN builds.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_L;
    logic [3:0]  anode_L;
    logic        err_clr;
    logic [15:0] digit_val;
    logic [3:0]  digit_vld;
    logic [3:0]  digit_err;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    int frame_wide = 0;
    logic fd_prev = 1'b0;

    seg_scan_decoder #(.STABLE_CYCLES(4), .DIGIT_MASK(4'b1111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_L      (seg_L),
        .anode_L    (anode_L),
`ifdef SEGDEC_STICKY_ERR_EN
        .err_clr    (err_clr),
`endif
        .digit_val  (digit_val),
        .digit_vld  (digit_vld),
        .digit_err  (digit_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) frame_cnt++;
        if (frame_done && fd_prev) frame_wide++;
        fd_prev = frame_done;
    end

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] val;
        logic [3:0]  vld;
        logic [3:0]  err;
        int          frames;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        anode_L = an;
        seg_L   = ~seg;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] v, input logic [3:0] vl,
                              input logic [3:0] er);
        check({tag, " val"}, 32'(digit_val), 32'(v));
        check({tag, " vld"}, 32'(digit_vld), 32'(vl));
        check({tag, " err"}, 32'(digit_err), 32'(er));
    endtask

    task automatic apply_vec(input int i);
        drive(vecs[i].an, vecs[i].seg);
        tick(vecs[i].hold);
        check_outs($sformatf("vec%0d", i), vecs[i].val, vecs[i].vld, vecs[i].err);
        check($sformatf("vec%0d frames", i), 32'(frame_cnt), 32'(vecs[i].frames));
    endtask

    logic [3:0] e_fix;

    initial begin
`ifdef SEGDEC_STICKY_ERR_EN
        e_fix = 4'b0100;
`else
        e_fix = 4'b0000;
`endif
        vecs[0] = '{4'b1110, 7'h7F, 10, 16'h0008, 4'b0001, 4'b0000, 0};
        vecs[1] = '{4'b1101, 7'h77, 10, 16'h00A8, 4'b0011, 4'b0000, 0};
        vecs[2] = '{4'b1011, 7'h7C, 10, 16'h0BA8, 4'b0111, 4'b0000, 0};
        vecs[3] = '{4'b0111, 7'h71, 10, 16'hFBA8, 4'b1111, 4'b0000, 1};
        vecs[4] = '{4'b1100, 7'h06, 20, 16'hFBA8, 4'b1111, 4'b0000, 1};
        vecs[5] = '{4'b1111, 7'h06, 20, 16'hFBA8, 4'b1111, 4'b0000, 1};
        vecs[6] = '{4'b1011, 7'h01, 10, 16'hFB88, 4'b1011, 4'b0100, 1};
        vecs[7] = '{4'b1011, 7'h06, 10, 16'hF188, 4'b1111, e_fix,   1};
        vecs[8] = '{4'b0111, 7'h00, 10, 16'hF188, 4'b0111, e_fix,   1};
        vecs[9] = '{4'b1110, 7'h3F, 10, 16'hF180, 4'b0111, e_fix,   2};

        rst_n   = 1'b0;
        err_clr = 1'b0;
        drive(4'b1111, 7'h00);
        #12;
        check_outs("reset", 16'h0000, 4'b0000, 4'b0000);
        check("reset frame_done", 32'(frame_done), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(3);

        // Capture latency: 2 sync + 4 dwell + 1 register.
        drive(4'b1110, 7'h5B);
        tick(6);
        check("latency early vld", 32'(digit_vld), 32'd0);
        tick(1);
        check_outs("latency", 16'h0002, 4'b0001, 4'b0000);

        for (int i = 0; i < 6; i++) apply_vec(i);

        // Glitch on digit 1: 3-cycle pattern then a stable '8'.
        drive(4'b1101, 7'h06);
        tick(3);
        drive(4'b1101, 7'h7F);
        tick(6);
        check("glitch no capture", 32'(digit_val), 32'hFBA8);
        tick(1);
        check_outs("glitch recover", 16'hFB88, 4'b1111, 4'b0000);

        for (int i = 6; i < 10; i++) apply_vec(i);

`ifdef SEGDEC_STICKY_ERR_EN
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        check("err_clr", 32'(digit_err), 32'd0);
`endif

        check("frame pulse width", 32'(frame_wide), 32'd0);

        // Async reset in the middle of a dwell.
        drive(4'b1101, 7'h4F);
        tick(4);
        rst_n = 1'b0;
        #1;
        check_outs("async reset", 16'h0000, 4'b0000, 4'b0000);
        check("async reset frame_done", 32'(frame_done), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check("post reset early vld", 32'(digit_vld), 32'd0);
        tick(1);
        check_outs("post reset", 16'h0030, 4'b0010, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
